// File: rtl/maxpool2x2_stream.sv
// Streaming 2x2 stride-2 max-pool over raster-order pixels with a half-width row buffer.
// Define MAXPOOL2X2_RELU_EN to clamp negative pooled results to zero.
module maxpool2x2_stream #(
    parameter int WIDTH  = 16,
    parameter int HEIGHT = 16,
    parameter int DATA_W = 18
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic signed [DATA_W-1:0] in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic signed [DATA_W-1:0] out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     frame_done
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam int RW = (HEIGHT > 2) ? $clog2(HEIGHT) : 1;
    localparam int HW = (WIDTH > 2) ? $clog2(WIDTH / 2) : 1;

    logic        [CW-1:0]     col;
    logic        [RW-1:0]     row;
    logic signed [DATA_W-1:0] hreg;
    logic signed [DATA_W-1:0] rowbuf [WIDTH/2];
    logic                     out_last;

    logic                     in_xfer;
    logic                     out_xfer;
    logic                     col_last;
    logic                     row_last;
    logic                     load;
    logic        [HW-1:0]     hidx;
    logic signed [DATA_W-1:0] hmax;
    logic signed [DATA_W-1:0] rb_q;
    logic signed [DATA_W-1:0] pool;
    logic signed [DATA_W-1:0] res;

    assign in_ready = !out_valid || out_ready;
    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = out_valid && out_ready;
    assign col_last = (col == CW'(WIDTH - 1));
    assign row_last = (row == RW'(HEIGHT - 1));
    assign hidx     = HW'(col >> 1);
    assign rb_q     = rowbuf[hidx];
    assign hmax     = (in_data > hreg) ? in_data : hreg;
    assign pool     = (rb_q > hmax) ? rb_q : hmax;
    assign load     = in_xfer && col[0] && row[0];

`ifdef MAXPOOL2X2_RELU_EN
    assign res = pool[DATA_W-1] ? '0 : pool;
`else
    assign res = pool;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col        <= '0;
            row        <= '0;
            hreg       <= '0;
            out_data   <= '0;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= out_xfer && out_last;
            if (in_xfer) begin
                if (!col[0]) begin
                    hreg <= in_data;
                end
                if (col_last) begin
                    col <= '0;
                    row <= row_last ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end
            // A new load takes priority over the handoff of the previous result.
            if (load) begin
                out_data  <= res;
                out_valid <= 1'b1;
                out_last  <= row_last && col_last;
            end else if (out_xfer) begin
                out_valid <= 1'b0;
            end
        end
    end

    // Row buffer holds no reset; it is always rewritten on the even row before use.
    always_ff @(posedge clk) begin
        if (in_xfer && col[0] && !row[0]) begin
            rowbuf[hidx] <= hmax;
        end
    end

endmodule
